// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-stationary array sequencer (weight preload, switch, skewed input streaming, drain); optional perf counter under SYSTOLIC_CTRL_PERF_EN
module systolic_ctrl #(
    parameter int N      = 2,
    parameter int VEC_AW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VEC_AW-1:0]    num_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic [$clog2(N)-1:0] w_rd_addr,
    output logic                 x_rd_en,
    output logic [VEC_AW-1:0]    x_rd_addr,
    output logic [N-1:0]         accept_w,
    output logic [N-1:0]         sw,
    output logic [N-1:0]         valid
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);
    localparam int WAW = $clog2(N);
    localparam int DW  = $clog2(2 * N) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, STREAM, DRAIN, FIN} state_t;

    state_t            state, state_n;
    logic [WAW-1:0]    w_cnt, w_cnt_n;
    logic [VEC_AW-1:0] x_cnt, x_cnt_n, nv, nv_n;
    logic [DW-1:0]     d_cnt, d_cnt_n;
    logic              x_last, busy_n, done_n, w_en_n, x_en_n, first_n, first;

    assign x_last    = x_cnt == nv - 1'b1;
    assign w_rd_addr = w_cnt;
    assign x_rd_addr = x_cnt;

    // state, phase counters and captured vector count
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            w_cnt <= '0;
            x_cnt <= '0;
            d_cnt <= '0;
            nv    <= '0;
        end else begin
            state <= state_n;
            w_cnt <= w_cnt_n;
            x_cnt <= x_cnt_n;
            d_cnt <= d_cnt_n;
            nv    <= nv_n;
        end

    // phase sequencing; weight rows are read top index first so they shift down into place
    always_comb begin
        state_n = state;
        w_cnt_n = w_cnt;
        x_cnt_n = x_cnt;
        d_cnt_n = d_cnt;
        nv_n    = nv;
        case (state)
            IDLE: if (start) begin
                nv_n    = num_vec;
                state_n = (num_vec != '0) ? LOAD_W : FIN;
                w_cnt_n = (num_vec != '0) ? WAW'(N - 1) : '0;
            end
            LOAD_W: begin
                state_n = (w_cnt == '0) ? SETTLE : LOAD_W;
                w_cnt_n = (w_cnt == '0) ? '0 : w_cnt - 1'b1;
            end
            SETTLE: begin
                state_n = STREAM;
                x_cnt_n = '0;
            end
            STREAM: begin
                state_n = x_last ? DRAIN : STREAM;
                x_cnt_n = x_last ? '0 : x_cnt + 1'b1;
                d_cnt_n = '0;
            end
            DRAIN: begin
                state_n = (d_cnt == DW'(2 * N - 1)) ? FIN : DRAIN;
                d_cnt_n = d_cnt + 1'b1;
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // next values of the registered strobes, decoded from the upcoming state
    always_comb begin
        busy_n  = state_n inside {LOAD_W, SETTLE, STREAM, DRAIN};
        done_n  = state_n == FIN;
        w_en_n  = state_n == LOAD_W;
        x_en_n  = state_n == STREAM;
        first_n = x_en_n && state != STREAM;
    end

    // registered outputs plus the per-row skew shift registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            w_rd_en  <= 1'b0;
            x_rd_en  <= 1'b0;
            first    <= 1'b0;
            accept_w <= '0;
            sw       <= '0;
            valid    <= '0;
        end else begin
            busy     <= busy_n;
            done     <= done_n;
            w_rd_en  <= w_en_n;
            x_rd_en  <= x_en_n;
            first    <= first_n;
            accept_w <= {N{w_rd_en}};
            valid    <= N'({valid, x_rd_en});
            sw       <= N'({sw, first});
        end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] run, run_n;

    assign run_n = (state == IDLE) ? 32'd1 : (&run ? run : run + 32'd1);

    // saturating job-length counter, published as the job enters its final cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            run         <= '0;
            perf_cycles <= '0;
        end else begin
            run <= run_n;
            if (state_n == FIN) perf_cycles <= run_n;
        end
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: per-cycle scoreboard of systolic_ctrl against a timeline model of each job
module tb_systolic_ctrl;
    localparam int N      = 2;
    localparam int VEC_AW = 8;
    localparam int WAW    = $clog2(N);

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [VEC_AW-1:0] num_vec = '0;
    logic              busy, done, w_rd_en, x_rd_en;
    logic [WAW-1:0]    w_rd_addr;
    logic [VEC_AW-1:0] x_rd_addr;
    logic [N-1:0]      accept_w, sw, valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    systolic_ctrl #(.N(N), .VEC_AW(VEC_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .accept_w(accept_w),
        .sw(sw), .valid(valid)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              w_en;
        logic [WAW-1:0]    w_addr;
        logic              x_en;
        logic [VEC_AW-1:0] x_addr;
        logic [N-1:0]      acc;
        logic [N-1:0]      sw;
        logic [N-1:0]      valid;
    } snap_t;

    typedef struct {
        int cyc;
        int perf;
    } done_t;

    snap_t exp_tab[int];
    done_t done_q[$];
    int    cyc = 0, busy_until = -1, checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t act();
        snap_t s;
        s.busy   = busy;
        s.done   = done;
        s.w_en   = w_rd_en;
        s.w_addr = w_rd_en ? w_rd_addr : '0;
        s.x_en   = x_rd_en;
        s.x_addr = x_rd_en ? x_rd_addr : '0;
        s.acc    = accept_w;
        s.sw     = sw;
        s.valid  = valid;
        return s;
    endfunction

    function automatic snap_t get(int c);
        return exp_tab.exists(c) ? exp_tab[c] : '0;
    endfunction

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, a, e);
        end
    endtask

    // model: a job accepted at cycle c0 lays out its whole output timeline
    task automatic sched(int c0, int n);
        snap_t s;
        int    d;
        if (n == 0) begin
            d = c0 + 1;
            s = get(d); s.done = 1'b1; exp_tab[d] = s;
            done_q.push_back('{d, 1});
            busy_until = d;
            return;
        end
        for (int i = 0; i < N; i++) begin
            s = get(c0 + 1 + i); s.w_en = 1'b1; s.w_addr = WAW'(N - 1 - i); exp_tab[c0 + 1 + i] = s;
            s = get(c0 + 2 + i); s.acc = '1; exp_tab[c0 + 2 + i] = s;
        end
        for (int k = 0; k < n; k++) begin
            s = get(c0 + N + 2 + k); s.x_en = 1'b1; s.x_addr = VEC_AW'(k); exp_tab[c0 + N + 2 + k] = s;
            for (int r = 0; r < N; r++) begin
                s = get(c0 + N + 3 + k + r);
                s.valid[r] = 1'b1;
                if (k == 0) s.sw[r] = 1'b1;
                exp_tab[c0 + N + 3 + k + r] = s;
            end
        end
        d = c0 + 3 * N + n + 2;
        for (int c = c0 + 1; c < d; c++) begin
            s = get(c); s.busy = 1'b1; exp_tab[c] = s;
        end
        s = get(d); s.done = 1'b1; exp_tab[d] = s;
        done_q.push_back('{d, 3 * N + n + 2});
        busy_until = d;
    endtask

    // monitor: compare every cycle on the falling edge, retire done events from the queue
    always @(negedge clk) begin
        snap_t e;
        done_t d;
        e = get(cyc);
        exp_tab.delete(cyc);
        chk("outputs", 32'(act()), 32'(e));
        if (done && done_q.size() != 0) begin
            d = done_q.pop_front();
            chk("done_cycle", cyc, d.cyc);
`ifdef SYSTOLIC_CTRL_PERF_EN
            chk("perf_cycles", perf_cycles, d.perf);
`endif
        end
    end

    task automatic pulse(int n);
        start   = 1'b1;
        num_vec = VEC_AW'(n);
        if (cyc > busy_until) sched(cyc, n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle_wait();
        while (cyc <= busy_until) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        // plain job, zero-length job
        pulse(3);
        idle_wait();
        pulse(0);
        idle_wait();
        // ignored starts mid-job and in the final cycle, num_vec change mid-job, back-to-back start
        c0 = cyc;
        pulse(3);
        wait_cyc(c0 + 2);
        num_vec = 8'd7;
        wait_cyc(c0 + 4);
        pulse(7);
        wait_cyc(c0 + 11);
        pulse(5);
        pulse(3);
        idle_wait();
        // asynchronous abort during streaming, then a clean job
        c0 = cyc;
        pulse(3);
        wait_cyc(c0 + 4);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_tab.delete();
        done_q.delete();
        #1 chk("rst_async", 32'(act()), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("perf_rst", perf_cycles, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        busy_until = -1;
        pulse(3);
        idle_wait();
        // random jobs with spurious starts and num_vec noise while busy
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse($urandom_range(0, 10));
            while (cyc <= busy_until) begin
                if ($urandom_range(0, 3) == 0) pulse($urandom_range(0, 15));
                else begin
                    num_vec = VEC_AW'($urandom);
                    @(negedge clk);
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for an N x N weight-stationary array of PEs.
- For each job: preloads one weight tile into the PE background registers, issues the switch to make it active, and streams num_vec input vectors with per-row diagonal skew.
- Waits for the array to drain, then pulses done.
- Sits between the unified buffer read ports and the array's north and west edges.

Parameters:
- N, 2, array dimension (rows = columns).
- VEC_AW, 8, width of the input-vector count and address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin job; sampled in IDLE only
- num_vec  in  VEC_AW  number of input vectors in the job; 0 is legal
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- w_rd_en  out  1  weight-row read strobe; buffer returns data next cycle
- w_rd_addr  out  $clog2(N)  weight-row address
- x_rd_en  out  1  input-vector read strobe; buffer returns data next cycle
- x_rd_addr  out  VEC_AW  input-vector index
- accept_w  out  N  per-column weight-accept into the array north edge
- sw  out  N  per-row switch into the array west edge
- valid  out  N  per-row valid into the array west edge

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high, all outputs are 0 and the FSM is in IDLE. Asserting rst mid-job aborts the job at once: no done pulse, no partial resume.
- FSM states: IDLE, LOAD_W, SETTLE, STREAM, DRAIN, FIN.
- IDLE:
  - start=1 and num_vec!=0 -> LOAD_W.
  - start=1 and num_vec==0 -> FIN.
  - num_vec is captured on the start cycle; later changes are ignored.
  - start while not in IDLE is ignored.
- LOAD_W:
  - Lasts N cycles.
  - w_rd_en=1; w_rd_addr counts N-1 down to 0, so row N-1 is pushed first and shifts down to the bottom PE row.
  - -> SETTLE.
- SETTLE:
  - Lasts 1 cycle; covers the last read's data latency.
  - -> STREAM.
- accept_w timing: accept_w is all-ones for exactly N cycles, each one cycle after a w_rd_en cycle (the last LOAD_W cycle and SETTLE included). At all other times it is 0.
- STREAM:
  - Lasts num_vec cycles.
  - x_rd_en=1; x_rd_addr counts 0 .. num_vec-1.
  - -> DRAIN.
- Row skew:
  - valid[r] equals x_rd_en delayed by r+1 cycles.
  - sw[r] is a one-cycle pulse coinciding with the first valid[r] of the job.
  - Implemented with per-row delay shift registers. These keep shifting during DRAIN and are cleared by rst.
- DRAIN:
  - Lasts 2N cycles.
  - Covers skew plus psum propagation to the south edge.
  - -> FIN.
- FIN:
  - Lasts 1 cycle; done=1, busy=0.
  - -> IDLE.
  - A start in the FIN cycle is ignored; the next job can start the following cycle.
- busy: 1 in LOAD_W, SETTLE, STREAM and DRAIN; 0 otherwise. All outputs are registered.
- Counters:
  - The LOAD_W counter is $clog2(N) bits.
  - The STREAM counter is VEC_AW bits and compares against captured num_vec-1. No wrap occurs since num_vec <= 2^VEC_AW-1.
  - The DRAIN counter is $clog2(2N)+1 bits.
- Latency from start to done: N + 1 + num_vec + 2N + 1 cycles; for num_vec=0 it is 1 cycle.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_EN.
- With the macro defined, an extra output port perf_cycles (32 bits) is present:
  - Zeroed on rst.
  - Holds the cycle count of the last completed job, counted from the cycle after start through the FIN cycle inclusive.
  - Updated in the FIN cycle.
  - Saturates at 32'hFFFFFFFF.
- Without the macro, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- N=2, start at t0 with num_vec=3 -> the following, with t0 = start cycle:
  - busy=1 over t1..t10.
  - w_rd_en at t1 (addr 1) and t2 (addr 0).
  - accept_w=2'b11 at t2..t3.
  - x_rd_en at t4..t6 (addr 0, 1, 2).
  - valid[0] at t5..t7, sw[0] at t5.
  - valid[1] at t6..t8, sw[1] at t6.
  - done at t11, busy=0 at t11.
- start with num_vec=0 -> done at t1, busy never 1, no read strobes, no accept_w/sw/valid.
- start re-asserted at t4 and at t11 of a num_vec=3 job -> both ignored. A start at t12 begins a new job with w_rd_en at t13.
- rst asserted asynchronously mid-STREAM (t5) -> all outputs 0 immediately, with no done pulse. After rst release, start runs a clean job with the timing of the first scenario.
- num_vec changed from 3 to 7 at t2 during a job -> the job still issues exactly 3 x_rd_en cycles.
- With SYSTOLIC_CTRL_PERF_EN defined -> perf_cycles=11 after the first scenario and 1 after the num_vec=0 scenario; 0 after rst.
